// File: rtl/sad_pkg.sv
// ----------------------------------------------------------------------------
// sad_pkg
// Shared widths, types and helpers for the best-motion-vector selector.
//   SAD4_W  : width of one 4x4-block SAD (16*255 = 4080 fits in 12 bits)
//   SAD8_W  : width of one 8x8 partition SAD (sum of four 4x4 SADs)
//   SAD16_W : width of the 16x16 macroblock SAD (sum of four 8x8 SADs)
//   MV_W    : signed width of one motion-vector component
//   CNT_W   : width of the saturating candidate counter
// ----------------------------------------------------------------------------
package sad_pkg;

    localparam int SAD4_W  = 12;
    localparam int SAD8_W  = SAD4_W + 2;
    localparam int SAD16_W = SAD4_W + 4;
    localparam int MV_W    = 8;
    localparam int CNT_W   = 10;

    typedef logic [SAD4_W-1:0]  sad4_t;
    typedef logic [SAD8_W-1:0]  sad8_t;
    typedef logic [SAD16_W-1:0] sad16_t;

    // Index order is [row/4][col/4] of the 16x16 macroblock.
    typedef sad4_t [0:3][0:3] sad4_grid_t;
    // Partition order: 0=TL, 1=TR, 2=BL, 3=BR.
    typedef sad8_t [0:3]      sad8_vec_t;

    typedef logic signed [MV_W-1:0] mvc_t;
    typedef struct packed {
        mvc_t x;
        mvc_t y;
    } mv_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } sel_state_e;

    // Sum of the four 4x4 SADs that make up 8x8 partition p.
    // p[1] selects the row pair, p[0] the column pair.
    function automatic sad8_t part_sum(input sad4_grid_t g, input logic [1:0] p);
        logic [1:0] r0, r1, c0, c1;
        r0 = {p[1], 1'b0};
        r1 = {p[1], 1'b1};
        c0 = {p[0], 1'b0};
        c1 = {p[0], 1'b1};
        return sad8_t'(g[r0][c0]) + sad8_t'(g[r0][c1])
             + sad8_t'(g[r1][c0]) + sad8_t'(g[r1][c1]);
    endfunction

endpackage

// File: rtl/sad_best_mv_select_if.sv
// ----------------------------------------------------------------------------
// sad_best_mv_select_if
// Bundles the search-control, candidate and result signals of the selector.
//   slave  : the selector itself (consumes candidates, produces results)
//   master : the search engine / mode decision side driving it
// Candidate channel : in_valid/in_ready/in_last, sad4x4, mv_x, mv_y
// Result channel    : out_valid/out_ready, best_* and cand_cnt
// ----------------------------------------------------------------------------
interface sad_best_mv_select_if;
    import sad_pkg::*;

    logic                    start;
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_last;
    sad4_grid_t              sad4x4;
    mvc_t                    mv_x;
    mvc_t                    mv_y;

    logic                    out_valid;
    logic                    out_ready;
    sad16_t                  best_sad16;
    mvc_t                    best_mv16_x;
    mvc_t                    best_mv16_y;
    sad8_vec_t               best_sad8;
    mvc_t [0:3]              best_mv8_x;
    mvc_t [0:3]              best_mv8_y;
    logic [CNT_W-1:0]        cand_cnt;

    modport slave (
        input  start, in_valid, in_last, sad4x4, mv_x, mv_y, out_ready,
        output in_ready, out_valid, best_sad16, best_mv16_x, best_mv16_y,
               best_sad8, best_mv8_x, best_mv8_y, cand_cnt
    );

    modport master (
        output start, in_valid, in_last, sad4x4, mv_x, mv_y, out_ready,
        input  in_ready, out_valid, best_sad16, best_mv16_x, best_mv16_y,
               best_sad8, best_mv8_x, best_mv8_y, cand_cnt
    );

endinterface

// File: rtl/sad_min_reg.sv
// ----------------------------------------------------------------------------
// sad_min_reg
// Holds one running-minimum SAD and the MV that produced it.
//   clk, rst_n : clock, synchronous active-low reset
//   clear      : start of a new search, zeroes the stored pair
//   upd        : a new candidate SAD/MV is presented this cycle
//   first      : first candidate of the search, always taken
//   sad_in     : candidate SAD
//   mv_in      : candidate MV
//   best_sad   : current minimum
//   best_mv    : MV of current minimum
// Ties keep the stored (earlier) candidate.
// ----------------------------------------------------------------------------
module sad_min_reg
    import sad_pkg::*;
#(
    parameter int W = SAD16_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         upd,
    input  logic         first,
    input  logic [W-1:0] sad_in,
    input  mv_t          mv_in,
    output logic [W-1:0] best_sad,
    output mv_t          best_mv
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_sad <= '0;
            best_mv  <= '0;
        end else if (clear) begin
            best_sad <= '0;
            best_mv  <= '0;
        end else if (upd && (first || (sad_in < best_sad))) begin
            best_sad <= sad_in;
            best_mv  <= mv_in;
        end
    end

endmodule

// File: rtl/sad_best_mv_select.sv
// ----------------------------------------------------------------------------
// sad_best_mv_select
// Picks the best 16x16 and per-8x8-partition motion vectors over a search.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : sad_best_mv_select_if.slave
//           start        - begins a search (honoured in IDLE only)
//           in_*/sad4x4/mv_x/mv_y - one candidate per cycle while searching
//           out_*/best_*/cand_cnt - result, held until out_ready
// Datapath: capture -> P1 (8x8 sums) -> P2 (16x16 sum) -> min registers.
// A candidate accepted at edge N reaches the min registers at edge N+3.
// ----------------------------------------------------------------------------
module sad_best_mv_select
    import sad_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    sad_best_mv_select_if.slave   bus
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_SEARCH = SEARCH;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_DONE   = DONE;

    logic [1:0]       state_q;
    logic [1:0]       drain_q;
    logic             first_q;
    logic [CNT_W-1:0] cnt_q;

    logic             accept;
    logic             clear;

    // Capture stage
    logic             s0_valid;
    sad4_grid_t       s0_grid;
    mv_t              s0_mv;
    // P1: partition sums
    logic             p1_valid;
    sad8_vec_t        p1_sad8;
    mv_t              p1_mv;
    // P2: macroblock sum
    logic             p2_valid;
    sad8_vec_t        p2_sad8;
    sad16_t           p2_sad16;
    mv_t              p2_mv;

    sad16_t           best16_sad;
    mv_t              best16_mv;
    sad8_vec_t        best8_sad;
    mv_t              best8_mv [0:3];

    assign bus.in_ready  = (state_q == ST_SEARCH);
    assign bus.out_valid = (state_q == ST_DONE);
    assign accept        = bus.in_valid && bus.in_ready;
    assign clear         = (state_q == ST_IDLE) && bus.start;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            drain_q  <= '0;
            first_q  <= 1'b0;
            cnt_q    <= '0;
            s0_valid <= 1'b0;
            p1_valid <= 1'b0;
            p2_valid <= 1'b0;
        end else begin
            s0_valid <= accept;
            p1_valid <= s0_valid;
            p2_valid <= p1_valid;

            if (p2_valid) begin
                first_q <= 1'b0;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_SEARCH;
                        first_q <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_SEARCH: begin
                    if (accept && bus.in_last) begin
                        state_q <= ST_DRAIN;
                        drain_q <= '0;
                    end
                end
                ST_DRAIN: begin
                    // Last candidate sits in capture at entry; two more
                    // edges move it through P1/P2, the third updates the
                    // min registers together with this transition.
                    if (drain_q == 2'd2) begin
                        state_q <= ST_DONE;
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // NOTE: pure datapath registers carry no reset; their contents are only
    // observed when the matching valid bit (which is reset) is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            s0_grid <= bus.sad4x4;
            s0_mv   <= '{x: bus.mv_x, y: bus.mv_y};
        end
        for (int p = 0; p < 4; p++) begin
            p1_sad8[p] <= part_sum(s0_grid, 2'(p));
        end
        p1_mv    <= s0_mv;
        p2_sad8  <= p1_sad8;
        p2_sad16 <= sad16_t'(p1_sad8[0]) + sad16_t'(p1_sad8[1])
                  + sad16_t'(p1_sad8[2]) + sad16_t'(p1_sad8[3]);
        p2_mv    <= p1_mv;
    end

    sad_min_reg #(.W(SAD16_W)) u_min16 (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .upd      (p2_valid),
        .first    (first_q),
        .sad_in   (p2_sad16),
        .mv_in    (p2_mv),
        .best_sad (best16_sad),
        .best_mv  (best16_mv)
    );

    for (genvar p = 0; p < 4; p++) begin : g_part
        sad_min_reg #(.W(SAD8_W)) u_min8 (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear),
            .upd      (p2_valid),
            .first    (first_q),
            .sad_in   (p2_sad8[p]),
            .mv_in    (p2_mv),
            .best_sad (best8_sad[p]),
            .best_mv  (best8_mv[p])
        );
    end

    assign bus.best_sad16  = best16_sad;
    assign bus.best_mv16_x = best16_mv.x;
    assign bus.best_mv16_y = best16_mv.y;
    assign bus.best_sad8   = best8_sad;
    assign bus.cand_cnt    = cnt_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        bus.best_mv8_x = '0;
        bus.best_mv8_y = '0;
        for (int p = 0; p < 4; p++) begin
            bus.best_mv8_x[p] = best8_mv[p].x;
            bus.best_mv8_y[p] = best8_mv[p].y;
        end
    end

endmodule

// File: tb/tb_sad_best_mv_select.sv
// ----------------------------------------------------------------------------
// tb_sad_best_mv_select
// Directed bench for sad_best_mv_select. Inputs change and outputs are
// sampled on the falling edge; the DUT samples on the rising edge.
// ----------------------------------------------------------------------------
module tb_sad_best_mv_select;
    import sad_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    sad_best_mv_select_if bus ();

    sad_best_mv_select dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic sad4_grid_t uniform(input int v);
        sad4_grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = sad4_t'(v);
        return g;
    endfunction

    // tl fills rows 0-1 / cols 0-1, rest fills the other twelve blocks.
    function automatic sad4_grid_t split_tl(input int tl, input int rest);
        sad4_grid_t g;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = (r < 2 && c < 2) ? sad4_t'(tl) : sad4_t'(rest);
        return g;
    endfunction

    task automatic start_search();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic send(input sad4_grid_t g, input int x, input int y, input logic last);
        bus.sad4x4   = g;
        bus.mv_x     = mvc_t'(x);
        bus.mv_y     = mvc_t'(y);
        bus.in_last  = last;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (!bus.out_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, longint'(bus.out_valid), 1);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check(tag, longint'(bus.out_valid), 0);
    endtask

    task automatic check_mv16(input string tag, input int x, input int y);
        check({tag, "_mv16_x"}, longint'(bus.best_mv16_x), x);
        check({tag, "_mv16_y"}, longint'(bus.best_mv16_y), y);
    endtask

    task automatic check_part(input string tag, input int p, input int sad,
                              input int x, input int y);
        check($sformatf("%s_sad8_%0d", tag, p), longint'(bus.best_sad8[p]), sad);
        check($sformatf("%s_mv8x_%0d", tag, p), longint'(bus.best_mv8_x[p]), x);
        check($sformatf("%s_mv8y_%0d", tag, p), longint'(bus.best_mv8_y[p]), y);
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.sad4x4    = '0;
        bus.mv_x      = '0;
        bus.mv_y      = '0;
        bus.out_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_in_ready",  longint'(bus.in_ready), 0);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_sad16",     longint'(bus.best_sad16), 0);
        check("rst_cnt",       longint'(bus.cand_cnt), 0);
        rst_n = 1'b1;
        tick();

        // 1: single candidate, latency
        start_search();
        check("t1_in_ready", longint'(bus.in_ready), 1);
        send(uniform(10), 3, -2, 1'b1);               // accepted at edge N
        check("t1_drain_in_ready", longint'(bus.in_ready), 0);
        tick();                                        // N+1
        tick();                                        // N+2
        check("t1_valid_n2", longint'(bus.out_valid), 0);
        tick();                                        // N+3
        check("t1_valid_n3", longint'(bus.out_valid), 1);
        check("t1_sad16", longint'(bus.best_sad16), 160);
        check_mv16("t1", 3, -2);
        for (int p = 0; p < 4; p++) check_part("t1", p, 40, 3, -2);
        check("t1_cnt", longint'(bus.cand_cnt), 1);
        release_result("t1_release");

        // 2: three candidates; start+in_valid together must not accept
        bus.sad4x4   = uniform(1);
        bus.mv_x     = mvc_t'(7);
        bus.mv_y     = mvc_t'(7);
        bus.in_valid = 1'b1;
        start_search();
        bus.in_valid = 1'b0;
        send(uniform(20), 0, 0, 1'b0);
        send(uniform(5),  1, 1, 1'b0);
        send(uniform(9),  2, 2, 1'b1);
        wait_done("t2_done", 10);
        check("t2_sad16", longint'(bus.best_sad16), 80);
        check_mv16("t2", 1, 1);
        check_part("t2", 2, 20, 1, 1);
        check("t2_cnt", longint'(bus.cand_cnt), 3);
        release_result("t2_release");

        // 3: tie keeps the earlier candidate
        start_search();
        send(uniform(7), -1, 0, 1'b0);
        send(uniform(7),  4, 4, 1'b1);
        wait_done("t3_done", 10);
        check("t3_sad16", longint'(bus.best_sad16), 112);
        check_mv16("t3", -1, 0);
        check_part("t3", 3, 28, -1, 0);
        release_result("t3_release");

        // 4: independent partitions
        start_search();
        send(split_tl(1, 50), 1, 0, 1'b0);   // sad8 {4,200,200,200}, sad16 604
        send(split_tl(60, 2), 0, 1, 1'b1);   // sad8 {240,8,8,8},     sad16 264
        wait_done("t4_done", 10);
        check("t4_sad16", longint'(bus.best_sad16), 264);
        check_mv16("t4", 0, 1);
        check_part("t4", 0, 4, 1, 0);
        for (int p = 1; p < 4; p++) check_part("t4", p, 8, 0, 1);
        check("t4_cnt", longint'(bus.cand_cnt), 2);

        // 5: backpressure with stray start/in_valid
        bus.sad4x4   = uniform(0);
        bus.mv_x     = mvc_t'(9);
        bus.mv_y     = mvc_t'(9);
        bus.in_last  = 1'b1;
        bus.in_valid = 1'b1;
        bus.start    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("t5_valid_%0d", i), longint'(bus.out_valid), 1);
            check($sformatf("t5_in_ready_%0d", i), longint'(bus.in_ready), 0);
            check($sformatf("t5_sad16_%0d", i), longint'(bus.best_sad16), 264);
            check($sformatf("t5_mv16x_%0d", i), longint'(bus.best_mv16_x), 0);
            check($sformatf("t5_cnt_%0d", i), longint'(bus.cand_cnt), 2);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.start    = 1'b0;
        release_result("t5_release");
        tick();
        check("t5_idle_in_ready", longint'(bus.in_ready), 0);
        check("t5_idle_valid",    longint'(bus.out_valid), 0);

        // 6: reset mid-search, then max values
        start_search();
        send(uniform(3), 5, 5, 1'b0);
        send(uniform(4), 6, 6, 1'b0);
        rst_n = 1'b0;
        tick();
        check("t6_rst_in_ready", longint'(bus.in_ready), 0);
        check("t6_rst_valid",    longint'(bus.out_valid), 0);
        check("t6_rst_sad16",    longint'(bus.best_sad16), 0);
        check("t6_rst_mv16x",    longint'(bus.best_mv16_x), 0);
        check("t6_rst_sad8",     longint'(bus.best_sad8[1]), 0);
        check("t6_rst_cnt",      longint'(bus.cand_cnt), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_partial", longint'(bus.out_valid), 0);
        check("t6_post_sad16", longint'(bus.best_sad16), 0);
        start_search();
        send(uniform(4095), -128, 127, 1'b1);
        wait_done("t6_done", 10);
        check("t6_sad16", longint'(bus.best_sad16), 65520);
        check_mv16("t6", -128, 127);
        check_part("t6", 3, 16380, -128, 127);
        check("t6_cnt", longint'(bus.cand_cnt), 1);
        release_result("t6_release");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
